// File: rtl/filter_seq_if.sv
// Handshake bundle for filter_seq: window/weight/bias input stream and the result stream.
// The slave modport is the filter itself; the master modport is whoever feeds and drains it.
interface filter_seq_if #(
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 32,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int InChannels  = 2
) ();
  localparam int KernelArea = KernelWidth * KernelWidth;

  logic [InChannels*KernelArea*WidthIn-1:0]     windows_i;
  logic [InChannels*KernelArea*WeightWidth-1:0] weights_i;
  logic [WidthOut-1:0]                          bias_i;
  logic                                         valid_i;
  logic                                         ready_o;
  logic [WidthOut-1:0]                          data_o;
  logic                                         valid_o;
  logic                                         ready_i;

  modport slave (
    input  windows_i, weights_i, bias_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  modport master (
    output windows_i, weights_i, bias_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/filter_seq.sv
// Time-multiplexed multi-channel filter: MACs ChPerCycle channels per clock, adds bias, saturates.
// Optional macro FILTER_SEQ_RELU_EN forces negative saturated results to zero.
module filter_seq #(
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 32,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int InChannels  = 2,
  parameter int ChPerCycle  = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  filter_seq_if.slave   bus
);
  localparam int KernelArea = KernelWidth * KernelWidth;
  localparam int AccWidth   = WidthIn + WeightWidth + $clog2(KernelArea * InChannels) + 2;
  // Common width for acc + bias so neither operand is truncated before saturation.
  localparam int SumW       = ((AccWidth > WidthOut) ? AccWidth : WidthOut) + 1;
  localparam int CntW       = $clog2(InChannels + 1);
  localparam int WinW       = InChannels * KernelArea * WidthIn;
  localparam int WtW        = InChannels * KernelArea * WeightWidth;

  localparam logic signed [SumW-1:0] SAT_MAX = {{(SumW-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
  localparam logic signed [SumW-1:0] SAT_MIN = {{(SumW-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};
  localparam logic [CntW-1:0]        LAST_CNT = CntW'(InChannels - ChPerCycle);
  localparam logic [CntW-1:0]        CNT_STEP = CntW'(ChPerCycle);

  if ((InChannels % ChPerCycle) != 0) begin : g_bad_cfg
    $error("filter_seq: ChPerCycle (%0d) must divide InChannels (%0d)", ChPerCycle, InChannels);
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state_r;
  state_t                      state_next_s;
  logic [WinW-1:0]             windows_r;
  logic [WtW-1:0]              weights_r;
  logic signed [WidthOut-1:0]  bias_r;
  logic signed [AccWidth-1:0]  acc_r;
  logic [CntW-1:0]             counter_r;

  logic signed [AccWidth-1:0]  group_sum_s;
  logic signed [AccWidth-1:0]  acc_next_s;
  logic signed [AccWidth-1:0]  pix_ext_s;
  logic signed [AccWidth-1:0]  wt_ext_s;
  logic [WidthIn-1:0]          pix_s;
  logic signed [WeightWidth-1:0] wt_s;
  logic signed [SumW-1:0]      sum_s;
  logic [WidthOut-1:0]         sat_s;
  logic [WidthOut-1:0]         out_s;
  logic                        accept_s;
  logic                        last_group_s;

  function automatic logic [WidthOut-1:0] sat(input logic signed [SumW-1:0] v);
    logic [WidthOut-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[WidthOut-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[WidthOut-1:0];
    end else begin
      r = v[WidthOut-1:0];
    end
    return r;
  endfunction

  assign accept_s     = bus.valid_i && bus.ready_o;
  assign last_group_s = (counter_r == LAST_CNT);

  // MAC datapath: sum of the current channel group, then acc + bias with saturation.
  always_comb begin
    group_sum_s = '0;
    pix_s       = '0;
    wt_s        = '0;
    pix_ext_s   = '0;
    wt_ext_s    = '0;
    for (int j = 0; j < ChPerCycle; j++) begin
      for (int k = 0; k < KernelArea; k++) begin
        pix_s       = windows_r[((int'(counter_r) + j) * KernelArea + k) * WidthIn +: WidthIn];
        wt_s        = weights_r[((int'(counter_r) + j) * KernelArea + k) * WeightWidth +: WeightWidth];
        pix_ext_s   = AccWidth'($signed({1'b0, pix_s}));
        wt_ext_s    = AccWidth'(wt_s);
        group_sum_s = group_sum_s + pix_ext_s * wt_ext_s;
      end
    end
    acc_next_s = acc_r + group_sum_s;
    sum_s      = SumW'(acc_next_s) + SumW'(bias_r);
    sat_s      = sat(sum_s);
`ifdef FILTER_SEQ_RELU_EN
    if (sat_s[WidthOut-1]) begin
      out_s = '0;
    end else begin
      out_s = sat_s;
    end
`else
    out_s = sat_s;
`endif
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (last_group_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      DONE: begin
        if (bus.valid_o && bus.ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand latches, accumulator and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      windows_r   <= '0;
      weights_r   <= '0;
      bias_r      <= '0;
      acc_r       <= '0;
      counter_r   <= '0;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
      bus.data_o  <= '0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            windows_r   <= bus.windows_i;
            weights_r   <= bus.weights_i;
            bias_r      <= bus.bias_i;
            acc_r       <= '0;
            counter_r   <= '0;
            bus.ready_o <= 1'b0;
          end
        end
        ACCUM: begin
          acc_r     <= acc_next_s;
          counter_r <= counter_r + CNT_STEP;
          if (last_group_s) begin
            bus.data_o  <= out_s;
            bus.valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (bus.valid_o && bus.ready_i) begin
            bus.valid_o <= 1'b0;
            bus.ready_o <= 1'b1;
          end
        end
        default: begin
          bus.valid_o <= 1'b0;
          bus.ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_filter_seq.sv
// Bench for filter_seq: three configurations (default, WidthOut=4, ChPerCycle=2) fed in lockstep
// and compared against an arithmetic reference model.
module tb_filter_seq;
  localparam int KA    = 9;
  localparam int NCH   = 2;
  localparam int WIN_W = NCH * KA;
  localparam int WT_W  = NCH * KA * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [WIN_W-1:0] win;
  logic [WT_W-1:0]  wts;
  logic [31:0]      bias_w;
  logic [3:0]       bias_n;
  logic             valid;
  logic             rdy;

  int tests = 0;
  int fails = 0;

  filter_seq_if                  bus_a ();
  filter_seq_if #(.WidthOut(4))  bus_s ();
  filter_seq_if                  bus_c ();

  assign bus_a.windows_i = win;  assign bus_a.weights_i = wts;  assign bus_a.bias_i = bias_w;
  assign bus_a.valid_i   = valid; assign bus_a.ready_i  = rdy;
  assign bus_s.windows_i = win;  assign bus_s.weights_i = wts;  assign bus_s.bias_i = bias_n;
  assign bus_s.valid_i   = valid; assign bus_s.ready_i  = rdy;
  assign bus_c.windows_i = win;  assign bus_c.weights_i = wts;  assign bus_c.bias_i = bias_w;
  assign bus_c.valid_i   = valid; assign bus_c.ready_i  = rdy;

  filter_seq                   dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
  filter_seq #(.WidthOut(4))   dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s.slave));
  filter_seq #(.ChPerCycle(2)) dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c.slave));

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain dot product over every channel and tap, bias added, clamped to wout bits.
  function automatic longint model(input logic [WIN_W-1:0] w_in, input logic [WT_W-1:0] wt_in,
                                   input longint b, input int wout);
    longint s = 0;
    longint hi, lo;
    logic signed [1:0] wv;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int k = 0; k < KA; k++) begin
        wv = wt_in[(ch*KA + k)*2 +: 2];
        s += longint'(w_in[ch*KA + k]) * longint'(wv);
      end
    end
    s += b;
    hi = (longint'(1) << (wout - 1)) - 1;
    lo = -(longint'(1) << (wout - 1));
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`ifdef FILTER_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic run_set(input logic [WIN_W-1:0] w_in, input logic [WT_W-1:0] wt_in,
                         input longint b_wide, input longint b_narrow, input int stall);
    longint exp_a, exp_s, dat_a, dat_s, dat_c;
    int lat_a, lat_s, lat_c;
    exp_a = model(w_in, wt_in, b_wide, 32);
    exp_s = model(w_in, wt_in, b_narrow, 4);
    lat_a = -1; lat_s = -1; lat_c = -1;
    dat_a = 0;  dat_s = 0;  dat_c = 0;
    win = w_in; wts = wt_in; bias_w = b_wide[31:0]; bias_n = b_narrow[3:0];
    valid = 1'b1;
    rdy = (stall == 0);
    check("ready_before", longint'(bus_a.ready_o & bus_s.ready_o & bus_c.ready_o), 1);
    @(posedge clk); #1;
    valid = 1'b0;
    win = WIN_W'($urandom); wts = {$urandom, 4'($urandom)}; bias_w = $urandom; bias_n = 4'($urandom);
    for (int cnt = 1; cnt <= 12; cnt++) begin
      if (cnt > 1) begin
        @(posedge clk); #1;
      end
      if (lat_a < 0 && bus_a.valid_o) begin lat_a = cnt; dat_a = longint'($signed(bus_a.data_o)); end
      if (lat_s < 0 && bus_s.valid_o) begin lat_s = cnt; dat_s = longint'($signed(bus_s.data_o)); end
      if (lat_c < 0 && bus_c.valid_o) begin lat_c = cnt; dat_c = longint'($signed(bus_c.data_o)); end
      if (lat_a >= 0 && lat_s >= 0 && lat_c >= 0) break;
    end
    check("lat_a", lat_a, 3);
    check("lat_s", lat_s, 3);
    check("lat_c", lat_c, 2);
    check("data_a", dat_a, exp_a);
    check("data_s", dat_s, exp_s);
    check("data_c", dat_c, exp_a);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("hold_data", longint'($signed(bus_a.data_o)), dat_a);
        check("hold_valid", longint'(bus_a.valid_o & bus_s.valid_o & bus_c.valid_o), 1);
        check("hold_ready", longint'(bus_a.ready_o | bus_s.ready_o | bus_c.ready_o), 0);
      end
      rdy = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_valid", longint'(bus_a.valid_o | bus_s.valid_o | bus_c.valid_o), 0);
    check("idle_ready", longint'(bus_a.ready_o & bus_s.ready_o & bus_c.ready_o), 1);
  endtask

  logic [WIN_W-1:0] ones;
  logic [WT_W-1:0]  w_basic, w_pos, w_neg;

  initial begin
    rst = 1'b1; valid = 1'b0; rdy = 1'b1;
    win = '0; wts = '0; bias_w = 32'd0; bias_n = 4'd0;
    ones = '1;
    for (int k = 0; k < KA; k++) begin
      w_basic[k*2 +: 2]      = 2'b01;
      w_basic[(KA+k)*2 +: 2] = (k == 0) ? 2'b01 : 2'b11;
    end
    for (int i = 0; i < NCH*KA; i++) begin
      w_pos[i*2 +: 2] = 2'b01;
      w_neg[i*2 +: 2] = 2'b10;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", longint'(bus_a.ready_o), 1);
    check("rst_valid", longint'(bus_a.valid_o | bus_s.valid_o | bus_c.valid_o), 0);
    check("rst_data", longint'(bus_a.data_o), 0);
    check("rst_data_s", longint'(bus_s.data_o), 0);
    rst = 1'b0;

    run_set(ones, w_basic, 5, 5, 0);
    check("basic_const", model(ones, w_basic, 5, 32), 7);
    run_set(ones, w_basic, 5, 5, 10);
    run_set(ones, w_pos, 0, 0, 0);
    run_set(ones, w_neg, 0, 0, 0);
    run_set(ones, w_pos, 64'sd2147483647, 7, 0);
    run_set(ones, w_neg, -64'sd2147483648, -8, 0);

    // Reset during the first ACCUM cycle must drop the set silently.
    win = ones; wts = w_pos; bias_w = 32'd3; bias_n = 4'd3; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("rst_mid_valid", longint'(bus_a.valid_o | bus_s.valid_o | bus_c.valid_o), 0);
      @(posedge clk); #1;
    end
    check("rst_mid_ready", longint'(bus_a.ready_o & bus_s.ready_o & bus_c.ready_o), 1);
    run_set(ones, w_basic, 5, 5, 0);

    for (int n = 0; n < 30; n++) begin
      logic [WIN_W-1:0] rw;
      logic [WT_W-1:0]  rt;
      longint           bw, bn;
      rw = WIN_W'($urandom);
      rt = {$urandom, 4'($urandom)};
      bw = (n % 5 == 0) ? longint'($signed($urandom)) : longint'($urandom_range(200, 0)) - 100;
      bn = longint'($urandom_range(15, 0)) - 8;
      run_set(rw, rt, bw, bn, (n % 7 == 3) ? 2 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
